// File: rtl/dual_input_debouncer.sv
// dual_input_debouncer
// Two independent channels. Each one runs a raw pin through a two-flop
// synchronizer and then a four-state debounce FSM. The FSM produces a
// registered clean level plus one-cycle rise/fall strobes.
// Both channels come from one generate body, so A and B use the same FSM logic.

module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  // Sparse encoding: any encoding not listed here falls into the default
  // branch and recovers to STABLE_LO.
  typedef enum logic [2:0] {
    ST_STABLE_LO = 3'b000,
    ST_WAIT_HI   = 3'b001,
    ST_STABLE_HI = 3'b010,
    ST_WAIT_LO   = 3'b011
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] raw_s;
  logic [1:0] db_s;
  logic [1:0] rise_s;
  logic [1:0] fall_s;

  assign raw_s = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic           s1_q;
    logic           s2_q;
    state_e         state_q;
    state_e         state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic           db_q;
    logic           db_d;
    logic           rise_q;
    logic           rise_d;
    logic           fall_q;
    logic           fall_d;

    // Two-flop synchronizer for the asynchronous raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= raw_s[ch];
        s2_q <= s1_q;
      end
    end

    // Debounce FSM state, stability counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_STABLE_LO;
        cnt_q   <= CNT_ZERO;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Next-state logic. The counter stops at CNT_LAST and never wraps.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ST_STABLE_LO: begin
          db_d  = 1'b0;
          cnt_d = CNT_ZERO;
          if (s2_q) begin
            state_d = ST_WAIT_HI;
          end else begin
            state_d = ST_STABLE_LO;
          end
        end
        ST_WAIT_HI: begin
          db_d = 1'b0;
          if (!s2_q) begin
            state_d = ST_STABLE_LO;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_HI;
            cnt_d   = CNT_ZERO;
            db_d    = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE_HI: begin
          db_d  = 1'b1;
          cnt_d = CNT_ZERO;
          if (!s2_q) begin
            state_d = ST_WAIT_LO;
          end else begin
            state_d = ST_STABLE_HI;
          end
        end
        ST_WAIT_LO: begin
          db_d = 1'b1;
          if (s2_q) begin
            state_d = ST_STABLE_HI;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_LO;
            cnt_d   = CNT_ZERO;
            db_d    = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE_LO;
          cnt_d   = CNT_ZERO;
          db_d    = 1'b0;
        end
      endcase
    end

    assign db_s[ch]   = db_q;
    assign rise_s[ch] = rise_q;
    assign fall_s[ch] = fall_q;
  end

  assign a_db   = db_s[0];
  assign b_db   = db_s[1];
  assign a_rise = rise_s[0];
  assign b_rise = rise_s[1];
  assign a_fall = fall_s[0];
  assign b_fall = fall_s[1];

endmodule

// File: doc/dual_input_debouncer.md
Name: dual_input_debouncer

Overview:
- Two-channel synchronizer and debouncer for the raw push-button/switch pins on the XC9536XL board.
- Feeds the clean levels a_db/b_db directly into the downstream two-input AND gate stage, in place of the raw pins.
- Also produces single-cycle rise/fall strobes for later pulse-driven stages.
- Sized for CPLD macrocell budget: one shared FSM definition instantiated per channel, small counters.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a level change; legal range 2..2**CNT_W.
CNT_W, 4, per-channel counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock from board oscillator; all state on rising edge
rst_n  input  1  asynchronous active-low reset
a_raw  input  1  raw, asynchronous, bouncing input A (pin)
b_raw  input  1  raw, asynchronous, bouncing input B (pin)
a_db  output  1  debounced level of A (to AND stage input a)
b_db  output  1  debounced level of B (to AND stage input b)
a_rise  output  1  one-cycle strobe when a_db goes 0->1
a_fall  output  1  one-cycle strobe when a_db goes 1->0
b_rise  output  1  one-cycle strobe when b_db goes 0->1
b_fall  output  1  one-cycle strobe when b_db goes 1->0

Behaviour:
- Reset (rst_n low, asynchronous): both synchronizer flops = 0, state = STABLE_LO, counter = 0, all outputs = 0. Release is not synchronized in this block; the board reset is held for many cycles.
- Synchronizer: two flops per channel, raw -> s1 -> s2. Only s2 is used downstream.
- Per-channel FSM (identical and fully independent for A and B). Each transition below fires on a clock edge:
  - STABLE_LO (db=0): if s2=1, go to WAIT_HI with cnt=0. Else stay.
  - WAIT_HI (db=0): if s2=0, go to STABLE_LO with cnt=0 (glitch rejected, no strobe). Else if cnt=DEBOUNCE_CYCLES-1, go to STABLE_HI, set db=1, assert rise for exactly one cycle. Else cnt+1.
  - STABLE_HI (db=1): if s2=0, go to WAIT_LO with cnt=0. Else stay.
  - WAIT_LO (db=1): symmetric to WAIT_HI, with s2=1 returning to STABLE_HI. On completion, db=0 and fall asserts for one cycle.
- db and the strobes are registered outputs. rise/fall are high only in the cycle immediately after the accepting edge, and never both high at once.
- Latency: raw held steady from before edge 0 gives db change visible after edge DEBOUNCE_CYCLES+2. That is DEBOUNCE_CYCLES+3 edges counted from edge 0.
- Acceptance threshold:
  - A raw level held for at least DEBOUNCE_CYCLES+1 cycles is accepted.
  - A level held for DEBOUNCE_CYCLES cycles or fewer is rejected, with db unchanged and no strobe.
- Bounce: any reversal in a WAIT state restarts from the matching STABLE state. The counter never wraps, because it stops at DEBOUNCE_CYCLES-1.
- Simultaneous events: A and B are evaluated independently. Both may change db and strobe in the same cycle.
- Reset mid-operation: asserting rst_n in any state (including WAIT_* with a partial count) forces the reset values immediately. No strobe is emitted.
- Unreachable state encodings recover to STABLE_LO with db=0 on the next edge.

Test Plan:
- Reset: rst_n=0 with a_raw=b_raw=1 -> all outputs 0 immediately. Release rst_n, keep raws high, DEBOUNCE_CYCLES=16 -> a_db/b_db rise 19 edges after release; a_rise/b_rise each high exactly 1 cycle.
- Glitch boundary (D=16): a_raw high for 16 cycles then low -> a_db stays 0, no a_rise. a_raw high for 17 cycles -> a_db=1, a_rise pulses once.
- Bounce: a_raw toggles 1,0,1,1,0,1 (one cycle each), then holds 1 -> a_db asserts 19 edges after the final 0->1 edge, with a single a_rise.
- Release path: from a_db=1, a_raw goes low and stays low -> a_db=0 after 19 edges; a_fall pulses 1 cycle; a_rise stays 0.
- Independence: a_raw and b_raw rise on the same cycle -> a_db and b_db rise on the same edge. Then b_raw glitches for 3 cycles while A is stable -> A outputs unaffected, b_db unchanged.
- Reset mid-WAIT: a_raw high 10 cycles, then pulse rst_n low for 1 cycle, a_raw still high -> a_db=0, no strobe. A full 19-edge latency restarts from the rst_n release.
